// File: rtl/alu_pkg.sv
// Shared definitions for the execution-stage ALU and the ALU control decoder.
// The operation codes here are the single source for the decoder's outputs.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_AND    = 4'b0000;
    localparam alu_op_t OP_ORR    = 4'b0001;
    localparam alu_op_t OP_ADD    = 4'b0010;
    localparam alu_op_t OP_SUB    = 4'b0110;
    localparam alu_op_t OP_PASS_B = 4'b0111;
    localparam alu_op_t OP_MUL    = 4'b1000;
    localparam alu_op_t OP_NOR    = 4'b1100;

    // Unit state: BUSY only exists while the iterative multiplier runs.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } unit_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add multiplier producing the low DATA_W bits of a*b.
// One multiplier bit is consumed per cycle after start_i; done_o is high
// during the final iteration, with product_o holding the finished product.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] multiplicand_i,
    input  logic [DATA_W-1:0] multiplier_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_step;

    // Partial-product accumulate for the current multiplier bit.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign product_o = acc_step;

    // Next-state: load on start, otherwise shift one bit per cycle while busy.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = multiplicand_i;
            mplier_d = multiplier_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Iteration state registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes on input and output.
// Single-cycle ops register result and NZCV flags on the transfer edge.
// Optional macro ALU_MUL_EN adds an iterative multiply (code 1000) that
// holds the unit BUSY; without it code 1000 is reported as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MUL_CNT_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ALU_operation,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic              illegal_op
);
    localparam int MSB = DATA_W - 1;

    if ((1 << MUL_CNT_W) != DATA_W) begin : g_bad_mul_cnt_w
        $error("alu_exec_unit: 2**MUL_CNT_W must equal DATA_W");
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;

    logic              unit_idle;
    logic              xfer;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_ill;

`ifdef ALU_MUL_EN
    unit_state_e       state_q, state_d;
    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_product;

    assign unit_idle = (state_q == IDLE);

    alu_seq_mul #(
        .DATA_W (DATA_W),
        .CNT_W  (MUL_CNT_W)
    ) u_mul (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (mul_start),
        .multiplicand_i (operand_a),
        .multiplier_i   (operand_b),
        .done_o         (mul_done),
        .product_o      (mul_product)
    );

    // Unit state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign unit_idle = 1'b1;
`endif

    // Accept only when idle and the output slot is free or draining now.
    assign in_ready = unit_idle && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    // Single-cycle datapath: result plus carry/overflow/illegal for the code.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (ALU_operation)
            OP_AND:    alu_res = operand_a & operand_b;
            OP_ORR:    alu_res = operand_a | operand_b;
            OP_NOR:    alu_res = ~(operand_a | operand_b);
            OP_PASS_B: alu_res = operand_b;
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, operand_a} + {1'b0, operand_b};
                alu_v = (operand_a[MSB] == operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
            end
            OP_SUB: begin
                {alu_c, alu_res} = {1'b0, operand_a} + {1'b0, ~operand_b} + {{DATA_W{1'b0}}, 1'b1};
                alu_v = (operand_a[MSB] != operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
            end
`ifdef ALU_MUL_EN
            OP_MUL:    alu_res = '0;
`endif
            default:   alu_ill = 1'b1;
        endcase
    end

    // Output register next-state: drain on out_ready, load on transfer or multiply done.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        mul_start   = 1'b0;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
`ifdef ALU_MUL_EN
            if (ALU_operation == OP_MUL) begin
                mul_start = 1'b1;
                state_d   = BUSY;
            end else
`endif
            begin
                out_valid_d = 1'b1;
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                neg_d       = alu_res[MSB];
                carry_d     = alu_c;
                ovf_d       = alu_v;
                ill_d       = alu_ill;
            end
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            result_d    = mul_product;
            zero_d      = (mul_product == '0);
            neg_d       = mul_product[MSB];
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            ill_d       = 1'b0;
        end
`endif
    end

    // Registered result, flags and output valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign carry      = carry_q;
    assign overflow   = ovf_q;
    assign illegal_op = ill_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU. Consumes the 4-bit ALU_operation code from the ALU control decoder, plus two 64-bit operands.
- Produces a registered 64-bit result and NZCV-style flags.
- Uses a valid/ready handshake on both the input and output sides. This lets the pipeline stall on a busy unit (the optional iterative multiply) or a stalled consumer.

Parameters:
- DATA_W, 64, operand and result width.
- MUL_CNT_W, 6, iteration counter width; must satisfy 2**MUL_CNT_W == DATA_W.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request this cycle
- ALU_operation  input  4  operation code
- operand_a  input  DATA_W  first operand
- operand_b  input  DATA_W  second operand
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  DATA_W  operation result
- zero  output  1  result == 0
- negative  output  1  result[DATA_W-1]
- carry  output  1  carry out (ADD) / NOT borrow (SUB), else 0
- overflow  output  1  signed overflow (ADD/SUB), else 0
- illegal_op  output  1  accepted code was not a supported operation

Behaviour:
- Reset (async, reset_n low): state IDLE; out_valid, result, all flags, illegal_op = 0; counter = 0. Asserting reset mid-multiply aborts it with no output.
- Operation codes:
  - 0000 AND
  - 0001 ORR
  - 0010 ADD
  - 0110 SUB (a - b)
  - 0111 PASS_B (result = operand_b; used for CBZ zero test)
  - 1100 NOR
  - 1000 MUL (only with the optional feature)
  - Any other code: result = 0, zero = 1, N/C/V = 0, illegal_op = 1.
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - Operands and code are sampled only on transfer.
- Single-cycle ops: result and flags are registered on the transfer edge, and out_valid rises the next cycle (latency 1).
  - Back-to-back transfers give throughput 1/cycle while out_ready = 1.
- Output handshake:
  - out_valid stays high, and result/flags stay stable, until out_ready is sampled high.
  - out_valid then drops unless a new transfer happens in the same cycle, in which case the new result replaces the old one.
- Flags:
  - ADD: carry = bit DATA_W of (a + b) computed at DATA_W+1 bits; overflow = (a[msb] == b[msb]) && (r[msb] != a[msb]).
  - SUB: computed as a + ~b + 1; carry = 1 when a >= b unsigned; overflow = (a[msb] != b[msb]) && (r[msb] != a[msb]).
  - Logic, PASS_B and MUL: carry = overflow = 0.
  - zero and negative always reflect the registered result.
- Wrap-around: ADD/SUB results are modulo 2**DATA_W, e.g. 0xFFFF_FFFF_FFFF_FFFF + 1 = 0 with zero = 1, carry = 1.
- States:
  - IDLE: accepts operations.
  - BUSY: multiply iterating; in_ready = 0.
  - IDLE → BUSY on a MUL transfer. BUSY → IDLE after the final iteration, with the result registered and out_valid = 1.
- out_valid may already be high from a prior op when a MUL is accepted only if out_ready is high in that cycle, so no result is ever overwritten unconsumed.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: code 1000 = MUL, low DATA_W bits of a*b (signed and unsigned give identical low bits).
  - Radix-2 shift-add: one bit of the multiplier per cycle; the counter runs 0..DATA_W-1.
  - Latency is DATA_W + 1 cycles from transfer to out_valid, 65 for the default.
  - Flags per the rules above.
- Undefined: no multiplier datapath, counter or BUSY state; code 1000 is treated as illegal; in_ready = !out_valid || out_ready.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP typedef/localparams: OP_AND = 4'b0000, OP_ORR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_PASS_B = 4'b0111, OP_MUL = 4'b1000, OP_NOR = 4'b1100.
  - Unit state enum {IDLE, BUSY}.
  - The same package is the single source for the ALU control decoder's output codes.
- One sub-module, alu_seq_mul: the iterative multiplier, with a start/done interface and DATA_W parameter. It is instantiated only under ALU_MUL_EN.

Test Plan:
- ADD with a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → 1 cycle later result 0x8000_0000_0000_0000, negative = 1, overflow = 1, carry = 0, zero = 0.
- SUB with a = 5, b = 5, then a = 3, b = 5 → first result 0 with zero = 1, carry = 1; second result 0xFFFF_FFFF_FFFF_FFFE, negative = 1, carry = 0.
- Back-to-back AND/ORR/NOR/PASS_B at in_valid = 1, out_ready = 1 → four results on consecutive cycles, e.g. ORR 0xF0 | 0x0F = 0xFF, PASS_B b = 0 → zero = 1.
- out_ready held low 3 cycles after an ADD → in_ready = 0, result held stable; no new transfer accepted until the cycle out_ready = 1.
- Code 0011 → illegal_op = 1, result 0, zero = 1. Without ALU_MUL_EN, code 1000 gives the same response.
- With ALU_MUL_EN: MUL 0x1_0000_0001 × 3 → in_ready low for 64 cycles, out_valid at cycle 65 with result 0x3_0000_0003. A reset_n pulse at cycle 20 of a second MUL → all outputs 0, no out_valid.
